instr_fetch_sequencer: RTL and testbench

//   Sequences program execution for the SIMD processor. Fetches one 12-bit instruction
//   per cycle from the synchronous instruction memory and presents it to the decode stage.
//   On STOP it drains the execute/writeback pipeline and pulses done. It injects NOP while
//   the downstream stage stalls, and holds the in-flight instruction until the stall clears.

---
 rtl/simd_pkg.sv | 38 +++
 rtl/instr_hold_reg.sv | 41 ++++
 rtl/instr_fetch_sequencer.sv | 155 +++++++++++++++
 tb/tb_instr_fetch_sequencer.sv | 382 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simd_pkg.sv
`default_nettype none
// ============================================================================
// Package     : simd_pkg
// Description : Shared opcode, sequencer state and instruction-format types.
// Revision    : 1.0  initial release
// ============================================================================
package simd_pkg;

    localparam int OPCODE_LEN = 4;
    localparam int INSTR_LEN  = 12;

    typedef enum logic [OPCODE_LEN-1:0] {
        NOP          = 4'd0,
        LOAD_A       = 4'd1,
        LOAD_B       = 4'd2,
        ADD          = 4'd3,
        SUB          = 4'd4,
        MUL          = 4'd5,
        DOT          = 4'd6,
        BUFFER_RES_1 = 4'd7,
        BUFFER_RES_2 = 4'd8,
        STORE        = 4'd9,
        STOP         = 4'd10
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

    function automatic logic is_stop(input logic [INSTR_LEN-1:0] instr);
        return instr[OPCODE_LEN-1:0] == STOP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_hold_reg.sv
`default_nettype none
// ============================================================================
// Module      : instr_hold_reg
// Description : One-entry holding register for an instruction refused by a stall.
// Revision    : 1.0  initial release
// ============================================================================
module instr_hold_reg
    import simd_pkg::*;
#(
    parameter int WIDTH = INSTR_LEN
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_load,
    input  logic             i_unload,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;

    // Load wins over unload; the sequencer never requests both in one cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_data  <= '0;
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= 1'b1;
        end else if (i_unload) begin
            r_valid <= 1'b0;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_sequencer
// Description : Fetches one instruction per cycle, holds it across stalls,
//               drains after STOP and pulses done at program end.
// Revision    : 1.0  initial release
// ============================================================================
module instr_fetch_sequencer
    import simd_pkg::*;
#(
    parameter  int IMEM_DEPTH      = 256,
    parameter  int DRAIN_CYCLES    = 3,
    localparam int IMEM_ADDR_WIDTH = $clog2(IMEM_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       i_start,
    input  logic                       i_stall,
    output logic                       o_imem_en,
    output logic [IMEM_ADDR_WIDTH-1:0] o_imem_addr,
    input  logic [INSTR_LEN-1:0]       i_imem_read_data,
    output logic [INSTR_LEN-1:0]       o_instr_out,
    output logic                       o_instr_valid,
    output logic                       o_busy,
    output logic                       o_done,
    output logic                       o_pc_overflow
);

    localparam int DCW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    seq_state_t                 r_state;
    seq_state_t                 w_state_nxt;
    logic [IMEM_ADDR_WIDTH-1:0] r_pc;
    logic                       r_rd_pending;
    logic                       r_last_issued;
    logic [DCW-1:0]             r_drain_cnt;
    logic                       r_pc_overflow;

    logic                       w_run;
    logic                       w_arrive;
    logic                       w_stop_arrive;
    logic                       w_issue;
    logic                       w_pc_at_last;
    logic                       w_hold_load;
    logic                       w_hold_unload;
    logic [INSTR_LEN-1:0]       w_hold_data;
    logic                       w_hold_valid;
    logic [INSTR_LEN-1:0]       w_instr;
    logic                       w_valid;
    logic                       w_end_of_prog;
    logic                       w_set_overflow;

    assign w_run         = (r_state == RUN);
    assign w_arrive      = w_run && r_rd_pending;
    assign w_stop_arrive = w_arrive && is_stop(i_imem_read_data);
    assign w_issue       = w_run && !i_stall && !w_stop_arrive && !w_hold_valid && !r_last_issued;
    assign w_pc_at_last  = (int'(r_pc) == (IMEM_DEPTH - 1));

    instr_hold_reg #(
        .WIDTH (INSTR_LEN)
    ) u_hold (
        .clk      (clk),
        .rstn     (rstn),
        .i_load   (w_hold_load),
        .i_unload (w_hold_unload),
        .i_data   (i_imem_read_data),
        .o_data   (w_hold_data),
        .o_valid  (w_hold_valid)
    );

    // A held instruction always drains before any new arrival is considered.
    always_comb begin
        w_instr       = '0;
        w_valid       = 1'b0;
        w_hold_load   = 1'b0;
        w_hold_unload = 1'b0;
        if (w_run) begin
            if (w_hold_valid && !i_stall) begin
                w_instr       = w_hold_data;
                w_valid       = 1'b1;
                w_hold_unload = 1'b1;
            end else if (w_arrive && i_stall) begin
                w_hold_load = 1'b1;
            end else if (w_arrive) begin
                w_instr = i_imem_read_data;
                w_valid = 1'b1;
            end
        end
    end

    // Once the last address is issued, the next presentation is that word.
    assign w_end_of_prog  = w_valid && (is_stop(w_instr) || r_last_issued);
    assign w_set_overflow = w_valid && r_last_issued && !is_stop(w_instr);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (i_start) w_state_nxt = RUN;
            RUN:     if (w_end_of_prog) w_state_nxt = DRAIN;
            DRAIN:   if (r_drain_cnt == '0) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_pc          <= '0;
            r_rd_pending  <= 1'b0;
            r_last_issued <= 1'b0;
            r_drain_cnt   <= '0;
            r_pc_overflow <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_pc          <= '0;
                        r_rd_pending  <= 1'b0;
                        r_last_issued <= 1'b0;
                        r_pc_overflow <= 1'b0;
                    end
                end
                RUN: begin
                    r_rd_pending <= w_issue;
                    if (w_issue) begin
                        if (w_pc_at_last) r_last_issued <= 1'b1;
                        else              r_pc          <= r_pc + IMEM_ADDR_WIDTH'(1);
                    end
                    if (w_set_overflow) r_pc_overflow <= 1'b1;
                    if (w_end_of_prog)  r_drain_cnt   <= DCW'(DRAIN_CYCLES - 1);
                end
                DRAIN: begin
                    r_rd_pending <= 1'b0;
                    if (r_drain_cnt != '0) r_drain_cnt <= r_drain_cnt - DCW'(1);
                end
                default: r_rd_pending <= 1'b0;
            endcase
        end
    end

    assign o_imem_en     = w_issue;
    assign o_imem_addr   = r_pc;
    assign o_instr_out   = w_instr;
    assign o_instr_valid = w_valid;
    assign o_busy        = (r_state != IDLE);
    assign o_done        = (r_state == DONE);
    assign o_pc_overflow = r_pc_overflow;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_sequencer
// Description : Self-checking bench for instr_fetch_sequencer (8-word memory).
// Revision    : 1.0  initial release
// ============================================================================
module tb_instr_fetch_sequencer;

    localparam int DEPTH = 8;
    localparam int DRAIN = 3;
    localparam int MAXC  = 128;
    localparam logic [3:0] STOP_OP = 4'd10;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic        stall;
    logic        imem_en;
    logic [2:0]  imem_addr;
    logic [11:0] rdata = 12'h000;
    logic [11:0] instr_out;
    logic        instr_valid;
    logic        busy;
    logic        done;
    logic        pc_overflow;

    logic [11:0] mem [DEPTH];

    int n_checks = 0;
    int n_errors = 0;

    bit start_at [MAXC];
    bit stall_at [MAXC];
    bit rst_at   [MAXC];

    logic        en_log   [MAXC];
    logic [2:0]  addr_log [MAXC];
    logic [11:0] ins_log  [MAXC];
    logic        val_log  [MAXC];
    logic        busy_log [MAXC];
    logic        done_log [MAXC];
    logic        ovf_log  [MAXC];

    int          addr_q[$];
    int          addr_cyc_q[$];
    logic [11:0] pres_q[$];
    int          pres_cyc_q[$];
    int          done_q[$];

    instr_fetch_sequencer #(
        .IMEM_DEPTH   (DEPTH),
        .DRAIN_CYCLES (DRAIN)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .i_start          (start),
        .i_stall          (stall),
        .o_imem_en        (imem_en),
        .o_imem_addr      (imem_addr),
        .i_imem_read_data (rdata),
        .o_instr_out      (instr_out),
        .o_instr_valid    (instr_valid),
        .o_busy           (busy),
        .o_done           (done),
        .o_pc_overflow    (pc_overflow)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data appears the cycle after the read.
    always @(posedge clk) if (imem_en) rdata <= mem[imem_addr];

    task automatic clear_sched();
        for (int c = 0; c < MAXC; c++) begin
            start_at[c] = 1'b0;
            stall_at[c] = 1'b0;
            rst_at[c]   = 1'b0;
        end
    endtask

    task automatic load_prog1();
        mem[0] = 12'h001;   // LOAD_A @0
        mem[1] = 12'h002;   // LOAD_B @0
        mem[2] = 12'h003;   // ADD
        mem[3] = 12'h059;   // STORE @5
        mem[4] = 12'h00A;   // STOP
        mem[5] = 12'h3F4;
        mem[6] = 12'h7A5;
        mem[7] = 12'h0C6;
    endtask

    // Entered just after a posedge; cycle c spans the interval before edge c+1.
    task automatic run(input int ncyc);
        addr_q.delete(); addr_cyc_q.delete(); pres_q.delete(); pres_cyc_q.delete(); done_q.delete();
        for (int c = 0; c < ncyc; c++) begin
            start = start_at[c];
            stall = stall_at[c];
            rstn  = ~rst_at[c];
            @(negedge clk);
            en_log[c] = imem_en;  addr_log[c] = imem_addr; ins_log[c] = instr_out;
            val_log[c] = instr_valid; busy_log[c] = busy; done_log[c] = done; ovf_log[c] = pc_overflow;
            if (imem_en) begin addr_q.push_back(int'(imem_addr)); addr_cyc_q.push_back(c); end
            if (instr_valid) begin pres_q.push_back(instr_out); pres_cyc_q.push_back(c); end
            if (done) done_q.push_back(c);
            @(posedge clk); #1;
        end
        start = 1'b0; stall = 1'b0; rstn = 1'b1;
    endtask

    task automatic test_reset();
        rstn = 1'b0; start = 1'b0; stall = 1'b0;
        repeat (2) @(posedge clk);
        #1; @(negedge clk);
        n_checks++;
        if ({imem_en, imem_addr, instr_out, instr_valid, busy, done, pc_overflow} !== 20'h0) begin
            n_errors++;
            $display("FAIL reset_outputs: got en=%b addr=%0d instr=%h valid=%b busy=%b done=%b ovf=%b, want all 0",
                     imem_en, imem_addr, instr_out, instr_valid, busy, done, pc_overflow);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        load_prog1(); clear_sched(); start_at[0] = 1'b1; start_at[3] = 1'b1;
        run(16);
        n_checks++;
        if (addr_q.size() != 5 || pres_q.size() != 5) begin
            n_errors++;
            $display("FAIL basic_counts: got %0d issues %0d presentations, want 5 and 5", addr_q.size(), pres_q.size());
        end
        for (int i = 0; i < 5 && i < addr_q.size(); i++) begin
            n_checks++;
            if (addr_q[i] !== i || addr_cyc_q[i] !== i + 1) begin
                n_errors++;
                $display("FAIL basic_issue[%0d]: got addr %0d at cycle %0d, want addr %0d at cycle %0d",
                         i, addr_q[i], addr_cyc_q[i], i, i + 1);
            end
        end
        for (int i = 0; i < 5 && i < pres_q.size(); i++) begin
            n_checks++;
            if (pres_q[i] !== mem[i] || pres_cyc_q[i] !== i + 2) begin
                n_errors++;
                $display("FAIL basic_present[%0d]: got %h at cycle %0d, want %h at cycle %0d",
                         i, pres_q[i], pres_cyc_q[i], mem[i], i + 2);
            end
        end
        n_checks++;
        if (done_q.size() != 1 || done_q[0] !== 6 + DRAIN + 1) begin
            n_errors++;
            $display("FAIL basic_done: got %0d pulses first at %0d, want 1 at %0d",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, 6 + DRAIN + 1);
        end
        n_checks++;
        if (busy_log[9] !== 1'b1 || busy_log[10] !== 1'b1 || busy_log[11] !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_busy: got busy %b%b%b at cycles 9..11, want 110", busy_log[9], busy_log[10], busy_log[11]);
        end
    endtask

    task automatic test_stall_hold();
        int exp_a [5];
        int exp_p [5];
        exp_a = '{1, 2, 7, 8, 9};
        exp_p = '{2, 6, 8, 9, 10};
        load_prog1(); clear_sched(); start_at[0] = 1'b1;
        for (int c = 3; c <= 5; c++) stall_at[c] = 1'b1;
        run(20);
        n_checks++;
        if (addr_q.size() != 5 || pres_q.size() != 5) begin
            n_errors++;
            $display("FAIL hold_counts: got %0d issues %0d presentations, want 5 and 5", addr_q.size(), pres_q.size());
        end
        for (int i = 0; i < 5 && i < addr_q.size() && i < pres_q.size(); i++) begin
            n_checks++;
            if (addr_q[i] !== i || addr_cyc_q[i] !== exp_a[i] || pres_q[i] !== mem[i] || pres_cyc_q[i] !== exp_p[i]) begin
                n_errors++;
                $display("FAIL hold_seq[%0d]: got addr %0d@%0d instr %h@%0d, want addr %0d@%0d instr %h@%0d",
                         i, addr_q[i], addr_cyc_q[i], pres_q[i], pres_cyc_q[i], i, exp_a[i], mem[i], exp_p[i]);
            end
        end
        n_checks++;
        if (done_q.size() != 1 || done_q[0] !== 14) begin
            n_errors++;
            $display("FAIL hold_done: got %0d pulses first at %0d, want 1 at 14",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
        end
    endtask

    task automatic test_stop_stalled();
        load_prog1(); clear_sched(); start_at[0] = 1'b1;
        stall_at[6] = 1'b1; stall_at[7] = 1'b1;
        run(18);
        n_checks++;
        if (addr_q.size() != 5 || addr_cyc_q[addr_cyc_q.size()-1] !== 5) begin
            n_errors++;
            $display("FAIL stopstall_issue: got %0d issues, want 5 ending at cycle 5", addr_q.size());
        end
        n_checks++;
        if (pres_q.size() != 5 || pres_q[4] !== 12'h00A || pres_cyc_q[4] !== 8) begin
            n_errors++;
            $display("FAIL stopstall_present: got %0d presentations, want 5 with STOP at cycle 8", pres_q.size());
        end
        n_checks++;
        if (done_q.size() != 1 || done_q[0] !== 8 + DRAIN + 1) begin
            n_errors++;
            $display("FAIL stopstall_done: got %0d pulses first at %0d, want 1 at %0d",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, 8 + DRAIN + 1);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < DEPTH; i++) mem[i] = {8'(i * 17 + 3), 4'(i % 10)};
        clear_sched(); start_at[0] = 1'b1;
        run(18);
        n_checks++;
        if (addr_q.size() != DEPTH || pres_q.size() != DEPTH) begin
            n_errors++;
            $display("FAIL ovf_counts: got %0d issues %0d presentations, want %0d each", addr_q.size(), pres_q.size(), DEPTH);
        end
        for (int i = 0; i < DEPTH && i < addr_q.size() && i < pres_q.size(); i++) begin
            n_checks++;
            if (addr_q[i] !== i || pres_q[i] !== mem[i] || pres_cyc_q[i] !== i + 2) begin
                n_errors++;
                $display("FAIL ovf_seq[%0d]: got addr %0d instr %h@%0d, want addr %0d instr %h@%0d",
                         i, addr_q[i], pres_q[i], pres_cyc_q[i], i, mem[i], i + 2);
            end
        end
        n_checks++;
        if (ovf_log[9] !== 1'b0 || ovf_log[10] !== 1'b1 || ovf_log[17] !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_flag: got %b%b%b at cycles 9,10,17, want 011", ovf_log[9], ovf_log[10], ovf_log[17]);
        end
        n_checks++;
        if (done_q.size() != 1 || done_q[0] !== 9 + DRAIN + 1) begin
            n_errors++;
            $display("FAIL ovf_done: got %0d pulses first at %0d, want 1 at %0d",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, 9 + DRAIN + 1);
        end
        load_prog1(); clear_sched(); start_at[0] = 1'b1;
        run(12);
        n_checks++;
        if (ovf_log[0] !== 1'b1 || ovf_log[1] !== 1'b0 || ovf_log[11] !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_clear: got %b%b%b at cycles 0,1,11, want 100", ovf_log[0], ovf_log[1], ovf_log[11]);
        end
    endtask

    task automatic test_reset_mid_run();
        load_prog1(); clear_sched(); start_at[0] = 1'b1;
        for (int c = 3; c <= 6; c++) stall_at[c] = 1'b1;
        rst_at[5] = 1'b1;
        run(8);
        n_checks++;
        if (pres_q.size() != 1 || val_log[3] !== 1'b0 || en_log[3] !== 1'b0) begin
            n_errors++;
            $display("FAIL midrst_hold: got %0d presentations valid@3=%b en@3=%b, want 1 0 0",
                     pres_q.size(), val_log[3], en_log[3]);
        end
        n_checks++;
        if ({en_log[6], addr_log[6], ins_log[6], val_log[6], busy_log[6], done_log[6], ovf_log[6]} !== 20'h0) begin
            n_errors++;
            $display("FAIL midrst_outputs: got en=%b addr=%0d instr=%h valid=%b busy=%b done=%b ovf=%b, want all 0",
                     en_log[6], addr_log[6], ins_log[6], val_log[6], busy_log[6], done_log[6], ovf_log[6]);
        end
        clear_sched(); start_at[0] = 1'b1;
        run(14);
        n_checks++;
        if (addr_q.size() != 5 || addr_q[0] !== 0 || addr_cyc_q[0] !== 1 || pres_q.size() != 5 || pres_q[1] !== mem[1]) begin
            n_errors++;
            $display("FAIL midrst_restart: got %0d issues first addr %0d, %0d presentations, want 5 from addr 0 and 5",
                     addr_q.size(), (addr_q.size() > 0) ? addr_q[0] : -1, pres_q.size());
        end
        n_checks++;
        if (done_q.size() != 1 || done_q[0] !== 10) begin
            n_errors++;
            $display("FAIL midrst_done: got %0d pulses first at %0d, want 1 at 10",
                     done_q.size(), (done_q.size() > 0) ? done_q[0] : -1);
        end
    endtask

    task automatic test_back_to_back();
        load_prog1(); clear_sched(); start_at[0] = 1'b1; start_at[11] = 1'b1;
        run(26);
        n_checks++;
        if (done_q.size() != 2 || done_q[0] !== 10 || done_q[1] !== 21) begin
            n_errors++;
            $display("FAIL b2b_done: got %0d pulses, want 2 at cycles 10 and 21", done_q.size());
        end
        n_checks++;
        if (addr_q.size() != 10 || pres_q.size() != 10) begin
            n_errors++;
            $display("FAIL b2b_counts: got %0d issues %0d presentations, want 10 each", addr_q.size(), pres_q.size());
        end
        for (int i = 0; i < 10 && i < addr_q.size() && i < pres_q.size(); i++) begin
            n_checks++;
            if (addr_q[i] !== i % 5 || addr_cyc_q[i] !== (i % 5) + 1 + (i / 5) * 11 ||
                pres_q[i] !== mem[i % 5] || pres_cyc_q[i] !== (i % 5) + 2 + (i / 5) * 11) begin
                n_errors++;
                $display("FAIL b2b_seq[%0d]: got addr %0d@%0d instr %h@%0d, want addr %0d@%0d instr %h@%0d",
                         i, addr_q[i], addr_cyc_q[i], pres_q[i], pres_cyc_q[i],
                         i % 5, (i % 5) + 1 + (i / 5) * 11, mem[i % 5], (i % 5) + 2 + (i / 5) * 11);
            end
        end
    endtask

    // Reference: the program is every word up to the first STOP (or the whole
    // memory); each word is issued and presented once, in order, never while
    // stalled, and done fires DRAIN+1 cycles after the final presentation.
    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            int stop_pos;
            int exp_len;
            bit exp_ovf;
            int bad;
            int last_p;
            int ncyc;
            ncyc = 100;
            stop_pos = $urandom_range(0, DEPTH);
            for (int i = 0; i < DEPTH; i++) begin
                logic [3:0] op;
                op = 4'($urandom_range(0, 15));
                if (op == STOP_OP) op = 4'd9;
                if (i == stop_pos) op = STOP_OP;
                mem[i] = {8'($urandom_range(0, 255)), op};
            end
            exp_len = DEPTH; exp_ovf = 1'b1;
            for (int i = DEPTH - 1; i >= 0; i--) if (mem[i][3:0] == STOP_OP) begin exp_len = i + 1; exp_ovf = 1'b0; end
            clear_sched(); start_at[0] = 1'b1;
            for (int c = 1; c < ncyc; c++) stall_at[c] = ($urandom_range(0, 99) < 35);
            run(ncyc);
            bad = 0;
            for (int i = 0; i < exp_len; i++) begin
                if (i >= addr_q.size() || addr_q[i] !== i) bad++;
                if (i >= pres_q.size() || pres_q[i] !== mem[i]) bad++;
            end
            n_checks++;
            if (bad != 0 || addr_q.size() != exp_len || pres_q.size() != exp_len) begin
                n_errors++;
                $display("FAIL rand_stream[%0d]: got %0d issues %0d presentations (%0d wrong), want %0d in order",
                         it, addr_q.size(), pres_q.size(), bad, exp_len);
            end
            bad = 0;
            for (int c = 0; c < ncyc; c++) begin
                if (!val_log[c] && ins_log[c] !== 12'h000) bad++;
                if (stall_at[c] && (val_log[c] || en_log[c])) bad++;
            end
            n_checks++;
            if (bad != 0) begin
                n_errors++;
                $display("FAIL rand_stall_nop[%0d]: got %0d bad cycles, want 0", it, bad);
            end
            last_p = (pres_cyc_q.size() > 0) ? pres_cyc_q[pres_cyc_q.size()-1] : -100;
            n_checks++;
            if (done_q.size() != 1 || done_q[0] !== last_p + DRAIN + 1) begin
                n_errors++;
                $display("FAIL rand_done[%0d]: got %0d pulses first at %0d, want 1 at %0d",
                         it, done_q.size(), (done_q.size() > 0) ? done_q[0] : -1, last_p + DRAIN + 1);
            end
            n_checks++;
            if (ovf_log[ncyc-1] !== exp_ovf || busy_log[ncyc-1] !== 1'b0) begin
                n_errors++;
                $display("FAIL rand_end[%0d]: got ovf=%b busy=%b, want ovf=%b busy=0",
                         it, ovf_log[ncyc-1], busy_log[ncyc-1], exp_ovf);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall_hold();
        test_stop_stalled();
        test_overflow();
        test_reset_mid_run();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
